bus_responder: RTL and testbench

Memory-mapped target on the processor's memory bus. It takes the processor's registered ADDR, DOUT and W and returns read data on DIN with one cycle of synchronous latency. This matches the processor's fetch, `ld` and `st` wait cycles. The block contains a word RAM, an LED output register, a synchronized switch input port and a down-counting interval timer. It sits at the top level between the processor and the board I/O.

---
 rtl/bus_responder.sv | 116 +++++++++++
 tb/tb_bus_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bus_responder.sv
// Memory-mapped bus target: word RAM, LED register, synchronized switch port
// and a down-counting interval timer, with one-cycle registered read data.
module bus_responder #(
  parameter int RAM_AW = 8
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] ADDR,
  input  logic [15:0] WrData,
  input  logic        W,
  input  logic [9:0]  SW,
  output logic [15:0] DIN,
  output logic [9:0]  LEDR,
  output logic        Irq
);

  logic [15:0] mem [0:(1<<RAM_AW)-1];
  logic [9:0]  sw_meta, sw_sync;
  logic [15:0] period, count;
  logic        en, ar, ie, flag;
  logic [15:0] rd_data;

  logic sel_ram, sel_led, sel_tmr;
  logic wr_period, wr_ctrl, wr_status;
  logic unused_addr;

  assign sel_ram   = (ADDR[15:12] == 4'h0);
  assign sel_led   = (ADDR[15:12] == 4'h1);
  assign sel_tmr   = (ADDR[15:12] == 4'h2);
  assign wr_period = W && sel_tmr && (ADDR[1:0] == 2'd0);
  assign wr_ctrl   = W && sel_tmr && (ADDR[1:0] == 2'd1);
  assign wr_status = W && sel_tmr && (ADDR[1:0] == 2'd2);
  assign unused_addr = ^ADDR[11:2];

  assign Irq = flag & ie;

  // RAM ignores reset: a store coinciding with reset still lands.
  always_ff @(posedge Clock) begin
    if (W && sel_ram)
      mem[ADDR[RAM_AW-1:0]] <= WrData;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn)
      LEDR <= '0;
    else if (W && sel_led)
      LEDR <= WrData[9:0];
  end

  // Register writes pre-empt the count step; a timeout set overrides a STATUS clear.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      period <= '0;
      count  <= '0;
      en     <= 1'b0;
      ar     <= 1'b0;
      ie     <= 1'b0;
      flag   <= 1'b0;
    end else begin
      if (wr_status)
        flag <= 1'b0;
      if (wr_period) begin
        period <= WrData;
        count  <= WrData;
      end else if (wr_ctrl) begin
        en <= WrData[0];
        ar <= WrData[1];
        ie <= WrData[2];
      end else if (en) begin
        if (count == '0) begin
          flag  <= 1'b1;
          count <= period;
          en    <= ar;
        end else begin
          count <= count - 16'd1;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (ADDR[15:12])
      4'h0: rd_data = mem[ADDR[RAM_AW-1:0]];
      4'h1: rd_data = {6'b0, LEDR};
      4'h2: begin
        case (ADDR[1:0])
          2'd0:    rd_data = period;
          2'd1:    rd_data = {13'b0, ie, ar, en};
          2'd2:    rd_data = {15'b0, flag};
          default: rd_data = count;
        endcase
      end
      4'h3: rd_data = {6'b0, sw_sync};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn)
      DIN <= '0;
    else
      DIN <= rd_data;
  end

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: stimulus pushes expectations per cycle,
// a monitor pops one entry after every rising edge and compares.
module tb_bus_responder;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [15:0] ADDR, WrData;
  logic        W;
  logic [9:0]  SW;
  logic [15:0] DIN;
  logic [9:0]  LEDR;
  logic        Irq;

  localparam int K_NONE = 0;
  localparam int K_DIN  = 1;
  localparam int K_LED  = 2;
  localparam int K_IRQ  = 3;

  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       nm;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  bus_responder #(.RAM_AW(8)) dut (
    .Clock(Clock), .Resetn(Resetn), .ADDR(ADDR), .WrData(WrData), .W(W),
    .SW(SW), .DIN(DIN), .LEDR(LEDR), .Irq(Irq)
  );

  always #5 Clock = ~Clock;

  // Drive one bus cycle at the falling edge; its expectation is checked after the next rising edge.
  task automatic step(input logic [15:0] a, input logic [15:0] d, input logic w,
                      input int kind, input logic [15:0] exp, input string nm);
    exp_t e;
    @(negedge Clock);
    ADDR = a; WrData = d; W = w;
    e.kind = kind; e.exp = exp; e.nm = nm;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    logic [15:0] act;
    forever begin
      @(posedge Clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.kind != K_NONE) begin
          case (e.kind)
            K_DIN:   act = DIN;
            K_LED:   act = {6'b0, LEDR};
            default: act = {15'b0, Irq};
          endcase
          tests++;
          if (act !== e.exp) begin
            fails++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", e.nm, act, e.exp);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    Resetn = 1'b0; ADDR = '0; WrData = '0; W = 1'b0; SW = '0;

    // reset; stores during reset reach RAM but not LEDR
    step(16'h1000, 16'h0000, 1'b0, K_DIN, 16'h0000, "rst_din");
    step(16'h0007, 16'h7777, 1'b1, K_LED, 16'h0000, "rst_led");
    step(16'h1000, 16'h03FF, 1'b1, K_LED, 16'h0000, "rst_ledw");
    step(16'h2000, 16'h0000, 1'b0, K_IRQ, 16'h0000, "rst_irq");
    Resetn = 1'b1;
    step(16'h1000, 16'h0000, 1'b0, K_DIN, 16'h0000, "led_rd0");
    step(16'h0000, 16'h0000, 1'b0, K_LED, 16'h0000, "led0");

    // RAM, alias, read-during-write
    step(16'h0005, 16'hBEEF, 1'b1, K_NONE, 16'h0000, "");
    step(16'h0005, 16'h0000, 1'b0, K_DIN, 16'hBEEF, "ram_rd");
    step(16'h0105, 16'h0000, 1'b0, K_DIN, 16'hBEEF, "ram_alias");
    step(16'h0007, 16'h0000, 1'b0, K_DIN, 16'h7777, "rst_store");
    step(16'h0003, 16'h1111, 1'b1, K_NONE, 16'h0000, "");
    step(16'h0003, 16'h2222, 1'b1, K_DIN, 16'h1111, "rdw_old");
    step(16'h0003, 16'h0000, 1'b0, K_DIN, 16'h2222, "rdw_new");
    step(16'h0000, 16'h1234, 1'b1, K_NONE, 16'h0000, "");

    // LEDR keeps only the low 10 bits
    step(16'h1000, 16'hFABC, 1'b1, K_LED, 16'h02BC, "led_wr");
    step(16'h1000, 16'h0000, 1'b0, K_DIN, 16'h02BC, "led_rd");

    // timer: PERIOD=3, CTRL=en|ar|ie -> timeout 4 edges after the CTRL write
    step(16'h2000, 16'h0003, 1'b1, K_NONE, 16'h0000, "");
    step(16'h2001, 16'h0007, 1'b1, K_IRQ, 16'h0000, "irq_e0");
    step(16'h2003, 16'h0000, 1'b0, K_IRQ, 16'h0000, "irq_e1");
    step(16'h2003, 16'h0000, 1'b0, K_DIN, 16'h0002, "cnt_e2");
    step(16'h2002, 16'h0000, 1'b0, K_IRQ, 16'h0000, "irq_e3");
    step(16'h2003, 16'h0000, 1'b0, K_IRQ, 16'h0001, "irq_e4");
    step(16'h2003, 16'h0000, 1'b0, K_DIN, 16'h0003, "cnt_reload");
    step(16'h2002, 16'h0000, 1'b0, K_DIN, 16'h0001, "flag_rd");
    step(16'h2002, 16'h0000, 1'b1, K_IRQ, 16'h0000, "irq_clr");
    step(16'h2003, 16'h0000, 1'b0, K_IRQ, 16'h0001, "irq_e8");
    step(16'h2002, 16'h0000, 1'b1, K_IRQ, 16'h0000, "clr2");
    step(16'h2003, 16'h0000, 1'b0, K_NONE, 16'h0000, "");
    step(16'h2003, 16'h0000, 1'b0, K_NONE, 16'h0000, "");
    step(16'h2002, 16'h0000, 1'b1, K_IRQ, 16'h0001, "set_wins");

    // one-shot: PERIOD=2, CTRL=en only
    step(16'h2002, 16'h0000, 1'b1, K_NONE, 16'h0000, "");
    step(16'h2000, 16'h0002, 1'b1, K_NONE, 16'h0000, "");
    step(16'h2001, 16'h0001, 1'b1, K_NONE, 16'h0000, "");
    step(16'h2002, 16'h0000, 1'b0, K_DIN, 16'h0000, "flag_lo");
    step(16'h2002, 16'h0000, 1'b0, K_NONE, 16'h0000, "");
    step(16'h2002, 16'h0000, 1'b0, K_DIN, 16'h0000, "flag_pre");
    step(16'h2002, 16'h0000, 1'b0, K_DIN, 16'h0001, "flag_once");
    step(16'h2001, 16'h0000, 1'b0, K_DIN, 16'h0000, "en_cleared");
    step(16'h2003, 16'h0000, 1'b0, K_DIN, 16'h0002, "cnt_hold");
    step(16'h2003, 16'h0000, 1'b0, K_NONE, 16'h0000, "");
    step(16'h2003, 16'h0000, 1'b0, K_DIN, 16'h0002, "cnt_hold2");
    step(16'h2001, 16'h0004, 1'b1, K_IRQ, 16'h0001, "irq_ie");
    step(16'h2002, 16'h0000, 1'b1, K_IRQ, 16'h0000, "irq_stclr");
    step(16'h2002, 16'h0000, 1'b0, K_DIN, 16'h0000, "flag_clr");

    // reset mid-count clears timer state
    step(16'h2000, 16'h0005, 1'b1, K_NONE, 16'h0000, "");
    step(16'h2001, 16'h0007, 1'b1, K_NONE, 16'h0000, "");
    step(16'h2003, 16'h0000, 1'b0, K_NONE, 16'h0000, "");
    Resetn = 1'b0;
    step(16'h2003, 16'h0000, 1'b0, K_NONE, 16'h0000, "");
    Resetn = 1'b1;
    step(16'h2003, 16'h0000, 1'b0, K_DIN, 16'h0000, "rst_cnt");
    step(16'h2000, 16'h0000, 1'b0, K_DIN, 16'h0000, "rst_per");
    step(16'h2001, 16'h0000, 1'b0, K_DIN, 16'h0000, "rst_ctrl");
    step(16'h1000, 16'h0000, 1'b0, K_LED, 16'h0000, "rst_led2");
    step(16'h1000, 16'h02BC, 1'b1, K_NONE, 16'h0000, "");

    // switch synchronizer latency, read-only and unmapped regions
    step(16'h3000, 16'h0000, 1'b0, K_NONE, 16'h0000, "");
    SW = 10'h2A5;
    step(16'h3000, 16'h0000, 1'b0, K_DIN, 16'h0000, "sw_e2");
    step(16'h3000, 16'h0000, 1'b0, K_DIN, 16'h02A5, "sw_e3");
    step(16'h3000, 16'hFFFF, 1'b1, K_DIN, 16'h02A5, "sw_wr");
    step(16'h3000, 16'h0000, 1'b0, K_DIN, 16'h02A5, "sw_ro");
    step(16'h8000, 16'hFFFF, 1'b1, K_DIN, 16'h0000, "unm_rd");
    step(16'h1000, 16'h0000, 1'b0, K_LED, 16'h02BC, "unm_led");
    step(16'h0000, 16'h0000, 1'b0, K_DIN, 16'h1234, "unm_ram");
    step(16'h0000, 16'h0000, 1'b0, K_NONE, 16'h0000, "");

    repeat (3) @(posedge Clock);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
